// File: rtl/seq_alu.sv
// seq_alu: registered ALU behind a valid/ready handshake, with a sequential shift-add multiplier.
// Optional sticky overflow flag (ov_clr/ov_sticky) when SEQ_ALU_OV_STICKY_EN is defined.
module seq_alu #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MUL_STEP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       sel,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             cout,
  output logic             negative,
  output logic             zero,
  output logic             overflow
`ifdef SEQ_ALU_OV_STICKY_EN
  ,
  input  logic             ov_clr,
  output logic             ov_sticky
`endif
);
  localparam int unsigned HALF  = WIDTH / 2;
  localparam int unsigned M     = WIDTH - 1;
  localparam int unsigned CNT_W = $clog2(WIDTH / MUL_STEP + 1);
  localparam logic [CNT_W-1:0] ITER_FULL = CNT_W'(WIDTH / MUL_STEP);
  localparam logic [CNT_W-1:0] ITER_HALF = CNT_W'(HALF / MUL_STEP);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               half_q, half_d;
  logic [WIDTH-1:0]   y_q, y_d;
  logic               cout_q, cout_d, neg_q, neg_d, zero_q, zero_d, ovf_q, ovf_d;
  logic               accept;

  logic [WIDTH:0]     add_s, sub_s;
  logic               add_v, sub_v;
  logic [WIDTH-1:0]   diff_abs;
  logic [WIDTH-1:0]   alu_y;
  logic               alu_c, alu_n, alu_v;

  assign add_s    = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, (sel == 4'b0110) & cin};
  assign sub_s    = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
  assign add_v    = (a[M] == b[M]) && (add_s[M] != a[M]);
  assign sub_v    = (a[M] != b[M]) && (sub_s[M] != a[M]);
  assign diff_abs = sub_s[M] ? (~sub_s[M:0] + WIDTH'(1)) : sub_s[M:0];

  always_comb begin
    alu_y = '0;
    alu_c = 1'b0;
    alu_n = 1'b0;
    alu_v = 1'b0;
    case (sel)
      4'b0000: alu_y = a & b;
      4'b0001: alu_y = a | b;
      4'b0010: alu_y = ~a;
      4'b0011: alu_y = ~(a | b);
      4'b0100: alu_y = a ^ b;
      4'b0101: alu_y = ~(a & b);
      4'b0110, 4'b1110: begin
        alu_y = add_s[M:0];
        alu_c = add_s[WIDTH];
        alu_v = add_v;
        alu_n = add_s[M];
      end
      4'b0111: begin
        alu_y = sub_s[M:0];
        alu_c = sub_s[WIDTH];
        alu_v = sub_v;
        alu_n = sub_s[M];
      end
      4'b1000: begin
        alu_y = diff_abs;
        alu_v = sub_v;
      end
      4'b1010, 4'b1011: begin
        alu_y = {a[M-1:0], 1'b0};
        alu_c = a[M];
        alu_v = (sel == 4'b1010) ? a[M] : (a[M] ^ a[M-1]);
        alu_n = a[M-1];
      end
      4'b1100: alu_y = {1'b0, a[M:1]};
      4'b1101: begin
        alu_y = {a[M], a[M:1]};
        alu_n = a[M];
      end
      default: alu_y = '0;
    endcase
  end

  // Right-shifting shift-add: high half accumulates, low half holds the remaining multiplier bits.
  logic [2*WIDTH-1:0] step;
  logic [WIDTH:0]     part;
  logic [WIDTH-1:0]   mul_y;
  logic               mul_hi_nz;

  always_comb begin
    step = acc_q;
    part = '0;
    for (int unsigned i = 0; i < MUL_STEP; i++) begin
      part = {1'b0, step[2*WIDTH-1:WIDTH]} + (step[0] ? {1'b0, mcand_q} : '0);
      step = {part, step[WIDTH-1:1]};
    end
  end

  assign mul_y     = half_q ? step[HALF +: WIDTH] : step[WIDTH-1:0];
  assign mul_hi_nz = !half_q && (step[2*WIDTH-1:WIDTH] != '0);

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    cnt_d    = cnt_q;
    half_d   = half_q;
    y_d      = y_q;
    cout_d   = cout_q;
    neg_d    = neg_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    accept   = 1'b0;
    in_ready = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
    case (state_q)
      S_IDLE: accept = in_valid;
      S_MUL: begin
        acc_d = step;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_DONE;
          y_d     = mul_y;
          cout_d  = 1'b0;
          neg_d   = !half_q && mul_y[M];
          zero_d  = (mul_y == '0);
          ovf_d   = mul_hi_nz;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
          accept  = in_valid;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (accept) begin
      if ((sel == 4'b1001) || (sel == 4'b1111)) begin
        state_d = S_MUL;
        half_d  = (sel == 4'b1001);
        if (sel == 4'b1001) begin
          mcand_d = {{HALF{1'b0}}, a[HALF-1:0]};
          acc_d   = {{(WIDTH + HALF){1'b0}}, b[HALF-1:0]};
          cnt_d   = ITER_HALF;
        end else begin
          mcand_d = a;
          acc_d   = {{WIDTH{1'b0}}, b};
          cnt_d   = ITER_FULL;
        end
      end else begin
        state_d = S_DONE;
        y_d     = alu_y;
        cout_d  = alu_c;
        neg_d   = alu_n;
        zero_d  = (alu_y == '0);
        ovf_d   = alu_v;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
      half_q  <= 1'b0;
      y_q     <= '0;
      cout_q  <= 1'b0;
      neg_q   <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
      half_q  <= half_d;
      y_q     <= y_d;
      cout_q  <= cout_d;
      neg_q   <= neg_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_valid = (state_q == S_DONE);
  assign y         = y_q;
  assign cout      = cout_q;
  assign negative  = neg_q;
  assign zero      = zero_q;
  assign overflow  = ovf_q;

`ifdef SEQ_ALU_OV_STICKY_EN
  logic sticky_q, sticky_d;

  always_comb begin
    sticky_d = sticky_q;
    if (out_valid && out_ready && ovf_q) sticky_d = 1'b1;
    else if (ov_clr)                     sticky_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) sticky_q <= 1'b0;
    else     sticky_q <= sticky_d;
  end

  assign ov_sticky = sticky_q;
`endif
endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: arithmetic reference model with per-cycle compare, directed cases and random traffic.
// Covers ov_clr/ov_sticky when SEQ_ALU_OV_STICKY_EN is defined.
module tb_seq_alu;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         cin = 1'b0;
  logic         out_ready = 1'b1;
  logic [3:0]   sel = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, out_valid, cout, negative, zero, overflow;
  logic [W-1:0] y;
`ifdef SEQ_ALU_OV_STICKY_EN
  logic         ov_clr = 1'b0;
  logic         ov_sticky;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(W), .MUL_STEP(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sel(sel), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready), .y(y),
    .cout(cout), .negative(negative), .zero(zero), .overflow(overflow)
`ifdef SEQ_ALU_OV_STICKY_EN
    , .ov_clr(ov_clr), .ov_sticky(ov_sticky)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: flags packed as {cout, negative, zero, overflow}; lat = cycles from accept to out_valid.
  function automatic void model(input logic [3:0] s, input logic [W-1:0] ia, input logic [W-1:0] ib,
                                input logic ic, output logic [W-1:0] ry, output logic [3:0] rf,
                                output int lat);
    longint          sa, sb, r;
    longint unsigned p;
    logic            c, n, v;
    logic [W-1:0]    d;
    longint          maxs, mins;
    maxs = 64'sh7FFFFFFF;
    mins = -64'sh80000000;
    sa = longint'($signed(ia));
    sb = longint'($signed(ib));
    c = 1'b0; n = 1'b0; v = 1'b0; ry = '0; lat = 1;
    case (s)
      4'h0: ry = ia & ib;
      4'h1: ry = ia | ib;
      4'h2: ry = ~ia;
      4'h3: ry = ~(ia | ib);
      4'h4: ry = ia ^ ib;
      4'h5: ry = ~(ia & ib);
      4'h6, 4'hE: begin
        p  = {32'h0, ia} + {32'h0, ib} + ((s == 4'h6) ? 64'(ic) : 64'd0);
        r  = sa + sb + ((s == 4'h6) ? longint'(ic) : 64'sd0);
        ry = p[31:0];
        c  = p > 64'hFFFF_FFFF;
        v  = (r > maxs) || (r < mins);
        n  = ry[31];
      end
      4'h7: begin
        r  = sa - sb;
        ry = ia - ib;
        c  = ia >= ib;
        v  = (r > maxs) || (r < mins);
        n  = ry[31];
      end
      4'h8: begin
        r  = sa - sb;
        d  = ia - ib;
        ry = ($signed(d) < 0) ? -d : d;
        v  = (r > maxs) || (r < mins);
      end
      4'h9: begin
        p   = {48'h0, ia[15:0]} * {48'h0, ib[15:0]};
        ry  = p[31:0];
        lat = 1 + (W / 2);
      end
      4'hA, 4'hB: begin
        ry = ia << 1;
        c  = ia[31];
        v  = (s == 4'hA) ? ia[31] : (ia[31] ^ ia[30]);
        n  = ry[31];
      end
      4'hC: ry = ia >> 1;
      4'hD: begin
        ry = $signed(ia) >>> 1;
        n  = ry[31];
      end
      default: begin
        p   = {32'h0, ia} * {32'h0, ib};
        ry  = p[31:0];
        v   = (p >> 32) != 0;
        n   = ry[31];
        lat = 1 + W;
      end
    endcase
    rf = {c, n, (ry == '0), v};
  endfunction

  // Per-cycle compare against the model; decisions for the next edge use the inputs stable at negedge.
  bit           chk_en = 1'b0, post_rst = 1'b0, busy = 1'b0, esticky = 1'b0;
  int           ncyc = 0, avail = 0;
  logic [W-1:0] ey = '0;
  logic [3:0]   ef = '0;

  always @(negedge clk) begin
    bit eov, eir;
    int lat;
    ncyc++;
    if (chk_en) begin
      eov = busy && (ncyc >= avail);
      eir = !busy || (eov && out_ready);
      check("out_valid", out_valid, eov);
      check("in_ready", in_ready, eir);
      if (eov || post_rst) begin
        check("y", y, post_rst ? '0 : ey);
        check("flags", {cout, negative, zero, overflow}, post_rst ? 4'b0 : ef);
      end
`ifdef SEQ_ALU_OV_STICKY_EN
      check("ov_sticky", ov_sticky, esticky);
`endif
      if (rst) begin
        busy = 1'b0; post_rst = 1'b1; esticky = 1'b0;
      end else begin
        post_rst = 1'b0;
`ifdef SEQ_ALU_OV_STICKY_EN
        if (eov && out_ready && ef[0]) esticky = 1'b1;
        else if (ov_clr)               esticky = 1'b0;
`endif
        if (eov && out_ready) busy = 1'b0;
        if (in_valid && eir) begin
          model(sel, a, b, cin, ey, ef, lat);
          busy  = 1'b1;
          avail = ncyc + lat;
        end
      end
    end else if (rst) begin
      chk_en = 1'b1; post_rst = 1'b1; busy = 1'b0; esticky = 1'b0;
    end
  end

  task automatic issue(input logic [3:0] s, input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic);
    int k;
    sel = s; a = ia; b = ib; cin = ic; in_valid = 1'b1;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (k == 100) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready got 0, expected 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; b = $urandom; sel = 4'($urandom); cin = 1'($urandom);
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!out_valid && cyc < 100);
    if (!out_valid) begin
      checks++; errors++;
      $display("FAIL out_valid_timeout: got 0, expected 1");
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom % 6)
      0: return '0;
      1: return 32'h8000_0000;
      2: return 32'h7FFF_FFFF;
      3: return '1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [W-1:0] py;
    logic [3:0]   pf;
    int           pl, c;

    model(4'h6, 32'h7FFFFFFF, 32'h1, 1'b0, py, pf, pl);
    check("pin_add_y", py, 32'h80000000); check("pin_add_f", pf, 4'b0101); check("pin_add_lat", pl, 1);
    model(4'h7, 32'h5, 32'h5, 1'b0, py, pf, pl);
    check("pin_sub_y", py, 0); check("pin_sub_f", pf, 4'b1010);
    model(4'h8, 32'h3, 32'hA, 1'b0, py, pf, pl);
    check("pin_abs_y", py, 7); check("pin_abs_f", pf, 4'b0000);
    model(4'h8, 32'h0, 32'h80000000, 1'b0, py, pf, pl);
    check("pin_abs_min_y", py, 32'h80000000); check("pin_abs_min_f", pf, 4'b0001);
    model(4'hF, 32'h00010000, 32'h00010000, 1'b0, py, pf, pl);
    check("pin_mul_y", py, 0); check("pin_mul_f", pf, 4'b0011); check("pin_mul_lat", pl, 33);
    model(4'h9, 32'hFFFF, 32'hFFFF, 1'b0, py, pf, pl);
    check("pin_mulh_y", py, 32'hFFFE0001); check("pin_mulh_f", pf, 4'b0000); check("pin_mulh_lat", pl, 17);
    model(4'hD, 32'h80000002, 32'h0, 1'b0, py, pf, pl);
    check("pin_asr_y", py, 32'hC0000001); check("pin_asr_f", pf, 4'b0100);
    model(4'hB, 32'h40000000, 32'h0, 1'b0, py, pf, pl);
    check("pin_shl_y", py, 32'h80000000); check("pin_shl_f", pf, 4'b0101);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    issue(4'h6, 32'h7FFFFFFF, 32'h1, 1'b0);
    wait_out(c);
    check("t1_lat", c, 1); check("t1_y", y, 32'h80000000);
    check("t1_flags", {cout, negative, zero, overflow}, 4'b0101);
    @(posedge clk); #1;

    issue(4'h7, 32'h5, 32'h5, 1'b0);
    wait_out(c);
    check("t2_sub_y", y, 0); check("t2_sub_flags", {cout, negative, zero, overflow}, 4'b1010);
    @(posedge clk); #1;
    issue(4'h8, 32'h3, 32'hA, 1'b0);
    wait_out(c);
    check("t2_abs_y", y, 7); check("t2_abs_neg", negative, 0);
    @(posedge clk); #1;

    issue(4'hF, 32'h00010000, 32'h00010000, 1'b0);
    wait_out(c);
    check("t3_mul_lat", c, 33); check("t3_mul_y", y, 0);
    check("t3_mul_flags", {cout, negative, zero, overflow}, 4'b0011);
    @(posedge clk); #1;
    issue(4'h9, 32'hFFFF, 32'hFFFF, 1'b0);
    wait_out(c);
    check("t3_mulh_lat", c, 17); check("t3_mulh_y", y, 32'hFFFE0001);
    @(posedge clk); #1;

    out_ready = 1'b0;
    issue(4'h0, 32'h12345678, 32'h0F0F0F0F, 1'b0);
    wait_out(c);
    repeat (5) begin
      @(negedge clk);
      check("t4_hold_y", y, 32'h02040608); check("t4_hold_valid", out_valid, 1);
      check("t4_hold_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b1; sel = 4'hD; a = 32'h80000002; b = '0;
    @(negedge clk);
    check("t4_b2b_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom;
    wait_out(c);
    check("t4_b2b_lat", c, 1); check("t4_b2b_y", y, 32'hC0000001); check("t4_b2b_neg", negative, 1);
    @(posedge clk); #1;

    issue(4'hF, 32'h12345, 32'h6789, 1'b0);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("t5_rst_valid", out_valid, 0); check("t5_rst_ready", in_ready, 1); check("t5_rst_y", y, 0);
    check("t5_rst_flags", {cout, negative, zero, overflow}, 4'b0000);
    @(posedge clk); #1;
    issue(4'h4, 32'hF0F0F0F0, 32'hFFFFFFFF, 1'b0);
    wait_out(c);
    check("t5_xor_y", y, 32'h0F0F0F0F);
    @(posedge clk); #1;

`ifdef SEQ_ALU_OV_STICKY_EN
    issue(4'hB, 32'h40000000, 32'h0, 1'b0);
    wait_out(c);
    check("t6_ovf", overflow, 1);
    @(posedge clk); #1;
    check("t6_sticky_set", ov_sticky, 1);
    issue(4'hC, 32'h12, 32'h0, 1'b0);
    wait_out(c);
    @(posedge clk); #1;
    check("t6_sticky_hold", ov_sticky, 1);
    ov_clr = 1'b1;
    @(posedge clk); #1;
    ov_clr = 1'b0;
    check("t6_sticky_clr", ov_sticky, 0);
`endif

    for (int i = 0; i < 5000; i++) begin
      in_valid  = ($urandom % 3) != 0;
      sel       = 4'($urandom);
      a         = pick();
      b         = pick();
      cin       = 1'($urandom);
      out_ready = ($urandom % 4) != 0;
      rst       = ($urandom % 400) == 0;
`ifdef SEQ_ALU_OV_STICKY_EN
      ov_clr    = ($urandom % 16) == 0;
`endif
      @(posedge clk); #1;
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
`ifdef SEQ_ALU_OV_STICKY_EN
    ov_clr = 1'b0;
`endif
    repeat (40) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
